// File: rtl/dsp_display_pkg.sv
// dsp_display_pkg: operand widths, seven-segment digit patterns and anode patterns
package dsp_display_pkg;
    localparam int A_W = 7;
    localparam int B_W = 8;
    localparam int C_W = 7;
    localparam int P_W = 16;
    localparam int M_W = A_W + B_W;
    // Active-low cathodes, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [3:0] AN_THOU = 4'b0111;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_UNIT = 4'b1110;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: decimal digit to active-low seven-segment pattern; non-decimal codes show "0"
module bcd_to_seg7
    import dsp_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_0;
        case (digit_i)
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_0;
        endcase
    end
endmodule

// File: rtl/dsp_macro_display.sv
// dsp_macro_display: 3-stage P = A*B + C pipeline with a once-per-second capture
// multiplexed onto a four-digit common-anode seven-segment display
module dsp_macro_display
    import dsp_display_pkg::*;
#(
    parameter int ONE_SEC_COUNT = 100_000_000,
    parameter int REFRESH_BITS  = 20
) (
    input  logic           clock_100Mhz,
    input  logic           reset,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic [C_W-1:0] C,
    output logic [P_W-1:0] P,
    output logic [3:0]     Anode_Activate,
    output logic [6:0]     LED_out
);
    localparam int CNT_W = ONE_SEC_COUNT > 1 ? $clog2(ONE_SEC_COUNT) : 1;

    logic [A_W-1:0]          a_q;
    logic [B_W-1:0]          b_q;
    logic [C_W-1:0]          c_q, c2_q;
    logic [M_W-1:0]          prod_q, prod_d;
    logic [P_W-1:0]          p_q, p_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [P_W-1:0]          disp_q, disp_d;
    logic                    tick;
    logic [1:0]              sel;
    logic [3:0]              thou, hund, tens, unit, digit;

    always_comb begin
        prod_d    = M_W'(a_q) * M_W'(b_q);
        p_d       = P_W'(prod_q) + P_W'(c2_q);
        tick      = cnt_q == CNT_W'(ONE_SEC_COUNT - 1);
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        disp_d    = tick ? p_q : disp_q;
        refresh_d = refresh_q + REFRESH_BITS'(1);
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            prod_q    <= '0;
            c2_q      <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            refresh_q <= '0;
            disp_q    <= '0;
        end else begin
            a_q       <= A;
            b_q       <= B;
            c_q       <= C;
            prod_q    <= prod_d;
            c2_q      <= c_q;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            refresh_q <= refresh_d;
            disp_q    <= disp_d;
        end
    end

    // Values of 10000 and above naturally show their low four decimal digits
    always_comb begin
        thou  = 4'((disp_q / P_W'(1000)) % P_W'(10));
        hund  = 4'((disp_q / P_W'(100)) % P_W'(10));
        tens  = 4'((disp_q / P_W'(10)) % P_W'(10));
        unit  = 4'(disp_q % P_W'(10));
        sel   = refresh_q[REFRESH_BITS-1 -: 2];
        digit = sel == 2'd0 ? thou : sel == 2'd1 ? hund : sel == 2'd2 ? tens : unit;
        Anode_Activate = sel == 2'd0 ? AN_THOU : sel == 2'd1 ? AN_HUND :
                         sel == 2'd2 ? AN_TENS : AN_UNIT;
    end

    bcd_to_seg7 u_seg (
        .digit_i (digit),
        .seg_o   (LED_out)
    );

    assign P = p_q;
endmodule

// File: tb/tb_dsp_macro_display.sv
// tb_dsp_macro_display: scoreboard bench for the multiply-add pipeline and display mux
module tb_dsp_macro_display;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  a = '0, c = '0;
    logic [7:0]  b = '0;
    logic [15:0] p;
    logic [3:0]  an;
    logic [6:0]  led;
    int checks = 0, errors = 0, cyc = 0, rel = 0;

    typedef struct {int due; int val;} exp_t;
    exp_t sb[$];

    dsp_macro_display #(.ONE_SEC_COUNT(10), .REFRESH_BITS(4)) dut (
        .clock_100Mhz   (clk),
        .reset          (reset),
        .A              (a),
        .B              (b),
        .C              (c),
        .P              (p),
        .Anode_Activate (an),
        .LED_out        (led)
    );

    always #5 clk = ~clk;

    // rel counts edges since the last reset edge; capture and refresh counters track it
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rel <= reset ? 0 : rel + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic [3:0] anode(input int s);
        case (s)
            0: return 4'b0111;
            1: return 4'b1011;
            2: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic int digit_at(input int n, input int s);
        case (s)
            0: return (n / 1000) % 10;
            1: return (n / 100) % 10;
            2: return (n / 10) % 10;
            default: return n % 10;
        endcase
    endfunction

    task automatic check_disp(input string tag, input int n, input int count);
        for (int i = 0; i < count; i++) begin
            int s;
            s = (rel % 16) / 4;
            check({tag, "_an"}, 32'(an), 32'(anode(s)));
            check({tag, "_seg"}, 32'(led), 32'(seg(digit_at(n, s))));
            @(negedge clk);
        end
    endtask

    task automatic step(input int x, input int y, input int z);
        exp_t e;
        a = 7'(x);
        b = 8'(y);
        c = 7'(z);
        e.due = cyc + 3;
        e.val = x * y + z;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_mod(input int r);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (rel % 10) == r;
        end
        if (!found) check("wait_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("P", 32'(p), 32'(sb[0].val));
            void'(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_P", 32'(p), 0);
        check_disp("rst", 0, 16);
        step(12, 34, 5);
        repeat (20) @(negedge clk);
        check_disp("d413", 413, 16);
        step(127, 255, 127);
        repeat (20) @(negedge clk);
        check_disp("dmax", 32512, 16);
        step(1, 1, 0);
        step(2, 2, 0);
        step(3, 3, 0);
        for (int i = 0; i < 20; i++)
            step(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
        step(12, 34, 5);
        repeat (20) @(negedge clk);
        // New operands timed so P changes on the tick edge itself
        wait_mod(7);
        step(100, 99, 0);
        wait_mod(0);
        check_disp("pre_tick", 413, 10);
        check_disp("post_tick", 9900, 16);
        step(12, 34, 5);
        repeat (20) @(negedge clk);
        wait_mod(7);
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_P", 32'(p), 0);
        check_disp("midrst", 0, 10);
        check_disp("recap", 413, 16);
        check("sb_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
